// File: rtl/twiddle_gen.sv
// Twiddle-factor sequencer for radix-2 FFT/IFFT stages: quarter-wave cosine
// table with mirror/sign logic, streaming one stage over valid/ready.
module twiddle_gen #(
  parameter int LOG2N = 5,
  parameter int DW    = 16,
  parameter int FRAC  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(LOG2N)-1:0]   stage,
  input  logic                       inverse,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [DW-1:0]       twid_re,
  output logic signed [DW-1:0]       twid_im,
  output logic [LOG2N-2:0]           twid_idx,
  output logic                       twid_last,
  output logic                       busy,
  output logic                       err
);

  localparam int N  = 1 << LOG2N;
  localparam int AW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam logic [SW:0]      STAGE_LIM = (SW+1)'(LOG2N);
  localparam logic [LOG2N-1:0] QTR       = LOG2N'(N / 4);
  localparam logic [LOG2N-1:0] HLF       = LOG2N'(N / 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  function automatic logic signed [DW-1:0] q_val(input int i);
    real ang;
    ang = 2.0 * 3.14159265358979323846 * real'(i) / real'(N);
    return DW'($rtoi($cos(ang) * real'(1 << FRAC)));
  endfunction

  logic signed [DW-1:0] qtab [0:N/4];

  for (genvar gi = 0; gi <= N/4; gi++) begin : g_qtab
    assign qtab[gi] = q_val(gi);
  end

  state_t               state_q, state_d;
  logic [AW-1:0]        k_q, k_d;
  logic [SW-1:0]        s_q, s_d;
  logic                 inv_q, inv_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 v1_q, v1_d;
  logic [AW-1:0]        ca1_q, ca1_d;
  logic [AW-1:0]        sa1_q, sa1_d;
  logic                 neg1_q, neg1_d;
  logic                 inv1_q, inv1_d;
  logic [AW-1:0]        idx1_q, idx1_d;
  logic                 last1_q, last1_d;

  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] re_q, re_d;
  logic signed [DW-1:0] im_q, im_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 last_q, last_d;

  logic                 adv, issue;
  logic [AW-1:0]        last_k;
  logic [SW-1:0]        shamt;
  logic [LOG2N-1:0]     e;
  logic [AW-1:0]        ca, sa;
  logic                 neg;
  logic signed [DW-1:0] cv, sv;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    s_d         = s_q;
    inv_d       = inv_q;
    busy_d      = busy_q;
    err_d       = 1'b0;
    v1_d        = v1_q;
    ca1_d       = ca1_q;
    sa1_d       = sa1_q;
    neg1_d      = neg1_q;
    inv1_d      = inv1_q;
    idx1_d      = idx1_q;
    last1_d     = last1_q;
    out_valid_d = out_valid_q;
    re_d        = re_q;
    im_d        = im_q;
    idx_d       = idx_q;
    last_d      = last_q;

    adv    = !out_valid_q || out_ready;
    issue  = (state_q == S_RUN) && adv;
    last_k = AW'((1 << s_q) - 1);
    shamt  = SW'(LOG2N - 1) - s_q;
    e      = LOG2N'(k_q) << shamt;

    // Fold the half-wave exponent onto the quarter table; second quadrant
    // reads the cosine mirrored and negated.
    if (e <= QTR) begin
      ca  = AW'(e);
      sa  = AW'(QTR - e);
      neg = 1'b0;
    end else begin
      ca  = AW'(HLF - e);
      sa  = AW'(e - QTR);
      neg = 1'b1;
    end

    cv = qtab[ca1_q];
    sv = qtab[sa1_q];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ({1'b0, stage} < STAGE_LIM) begin
            state_d = S_RUN;
            k_d     = '0;
            s_d     = stage;
            inv_d   = inverse;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          if (k_q == last_k) state_d = S_DRAIN;
          else               k_d     = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready && last_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      v1_d = issue;
      if (issue) begin
        ca1_d   = ca;
        sa1_d   = sa;
        neg1_d  = neg;
        inv1_d  = inv_q;
        idx1_d  = k_q;
        last1_d = (k_q == last_k);
      end
      out_valid_d = v1_q;
      if (v1_q) begin
        re_d   = neg1_q ? -cv : cv;
        im_d   = inv1_q ? sv : -sv;
        idx_d  = idx1_q;
        last_d = last1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      s_q         <= '0;
      inv_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      v1_q        <= 1'b0;
      ca1_q       <= '0;
      sa1_q       <= '0;
      neg1_q      <= 1'b0;
      inv1_q      <= 1'b0;
      idx1_q      <= '0;
      last1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      s_q         <= s_d;
      inv_q       <= inv_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      v1_q        <= v1_d;
      ca1_q       <= ca1_d;
      sa1_q       <= sa1_d;
      neg1_q      <= neg1_d;
      inv1_q      <= inv1_d;
      idx1_q      <= idx1_d;
      last1_q     <= last1_d;
      out_valid_q <= out_valid_d;
      re_q        <= re_d;
      im_q        <= im_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign twid_re   = re_q;
  assign twid_im   = im_q;
  assign twid_idx  = idx_q;
  assign twid_last = last_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
- Parametrised twiddle-factor sequencer for the radix-2 FFT/IFFT datapath; supersedes the fixed per-stage real/imaginary twiddle ROMs.
- Stores one quarter-wave cosine table and derives cos/sin for any exponent by mirroring and sign logic.
- On a start request it streams the full twiddle sequence for one butterfly stage over a valid/ready interface.
- A mode bit selects forward (W = cos − j·sin) or inverse (W = cos + j·sin) conjugation.

Parameters:
- LOG2N, 5, log2 of transform size N (N = 2^LOG2N); legal range 3..12.
- DW, 16, signed width of each twiddle output component.
- FRAC, 8, fractional bits; 1.0 = 2^FRAC (0x0100 at default).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- stage  in  $clog2(LOG2N)  stage index s, 0..LOG2N-1
- inverse  in  1  1 = IFFT conjugation (+sin), 0 = FFT (−sin)
- out_ready  in  1  downstream ready
- out_valid  out  1  twiddle output valid
- twid_re  out  DW  signed cos component
- twid_im  out  DW  signed ±sin component
- twid_idx  out  LOG2N-1  index k within the stage
- twid_last  out  1  high with the final twiddle of the stage
- busy  out  1  high from accepted start until last beat is consumed
- err  out  1  one-cycle pulse when start arrives with stage >= LOG2N

Behaviour:
- Table: Q[i] = trunc_toward_zero(2^FRAC · cos(2πi/N)) for i = 0..N/4; built at elaboration.
  - Default values: 0100, 00FB, 00EC, 00D4, 00B5, 008E, 0061, 0031, 0000.
- Sequence for stage s:
  - k = 0..2^s−1, exponent e = k · 2^(LOG2N−1−s), so 0 <= e < N/2.
- Mirroring:
  - e <= N/4: cos = Q[e], sin = Q[N/4−e].
  - e > N/4: cos = −Q[N/2−e], sin = Q[e−N/4].
- Output sign:
  - twid_im = −sin when inverse = 0, +sin when inverse = 1.
  - Two's complement, sign-extended to DW.
- FSM IDLE → RUN → DRAIN → IDLE:
  - IDLE: start with a legal stage latches stage and inverse, clears k, and moves to RUN.
  - IDLE: start with an illegal stage pulses err the next cycle and stays in IDLE.
  - RUN: issues one index into the pipe per advancing cycle; after issuing k = 2^s−1, moves to DRAIN.
  - DRAIN: waits until the last beat is consumed (out_valid & out_ready & twid_last), then returns to IDLE.
- Pipeline: 2 stages (exponent/mirror-address register, then ROM read plus sign register).
  - First out_valid appears 2 cycles after the start-accept edge.
  - One beat per cycle while out_ready = 1.
- Backpressure:
  - Pipe advance enable = !out_valid | out_ready; all stages stall together.
  - While out_valid = 1 and out_ready = 0, twid_re, twid_im, twid_idx and twid_last are held stable.
  - No beat is dropped or duplicated.
- Stage 0 yields a single beat (k = 0, W = 1 + j0) with twid_last = 1.
- start while busy = 1 is ignored; no err, and the sequence is unaffected.
- inverse and stage are captured at accept; changes during RUN have no effect.
- busy:
  - Rises the cycle after accept.
  - Falls the cycle after the last beat handshake.
  - A start on that same falling edge is not accepted; the new start is accepted the following cycle.
- Reset: rst_n low asynchronously forces IDLE and clears the pipe mid-operation.
  - All outputs reset to 0: out_valid, twid_re, twid_im, twid_idx, twid_last, busy, err.

Test Plan:
- Stage 2 forward, N=32, out_ready=1, start at cycle 0:
  - Expect beats at cycles 2..5: (0100,0000), (00B5,FF4B), (0000,FF00), (FF4B,FF4B).
  - twid_idx = 0..3; twid_last on idx 3; busy drops at cycle 6.
- Stage 2 inverse, same stimulus:
  - Expect (0100,0000), (00B5,00B5), (0000,0100), (FF4B,00B5).
- Stage 4 forward, out_ready toggled 1,0,0,1,...:
  - Expect exactly 16 beats with idx 0..15, data held stable across stalled cycles.
  - idx 1 = (00FB,FFCF); idx 8 = (0000,FF00); idx 15 = (FF05,FFCF).
- start with stage = 5 → err pulses one cycle, no out_valid, busy stays 0.
- start with stage = 0 → one beat (0100,0000) with twid_last = 1.
- start re-pulsed during RUN → ignored.
- rst_n asserted low mid-stage-3 at beat 2 → all outputs 0 immediately.
  - After release, a fresh stage-1 start yields (0100,0000), (0000,FF00).
